// File: rtl/iob_eth_mii_rx.sv
// MII receive path: strips the preamble/SFD, assembles nibbles into bytes and
// queues them in a small FIFO behind a valid/ready stream interface.
module iob_eth_mii_rx #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        cke_i,
  input  logic        mii_rx_dv_i,
  input  logic [3:0]  mii_rx_data_i,
  output logic [7:0]  m_data_o,
  output logic        m_last_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        frame_done_o,
  output logic [10:0] frame_len_o,
  output logic        frame_err_o,
  output logic        overflow_o
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [10:0] MaxLen = 11'(MAX_LEN);
  localparam logic [10:0] CntMax = 11'h7ff;

  typedef enum logic [2:0] {StIdle, StPreamble, StDataLo, StDataHi, StDrop} state_e;

  state_e state_q, state_d;

  // Set once dv has been seen low; keeps the block from locking onto a frame
  // that was already in flight when reset was released.
  logic        armed_q;
  logic [3:0]  lo_q;
  logic        stg_valid_q;
  logic [7:0]  stg_data_q;
  logic [10:0] cnt_q;
  logic        done_q, err_q, ovf_q;
  logic [10:0] len_q;

  logic [8:0]         mem_q [Depth];
  logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
  logic               fifo_empty, fifo_full, pop;
  logic [8:0]         rd_word;

  // FSM outputs
  logic cnt_clr, cnt_inc, stage_new, push, push_last, end_frame, end_err;
  logic push_ok, push_fail;

  // FIFO status and handshake
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    rd_word    = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    pop        = cke_i && !fifo_empty && m_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok    = push && (!fifo_full || pop);
    push_fail  = push && !push_ok;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
    end else if (cke_i) begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mii_rx_dv_i) begin
          state_d = (armed_q && mii_rx_data_i == 4'h5) ? StPreamble : StDrop;
        end
      end
      StPreamble: begin
        if (!mii_rx_dv_i)                state_d = StIdle;
        else if (mii_rx_data_i == 4'hd) state_d = StDataLo;
        else if (mii_rx_data_i != 4'h5) state_d = StDrop;
      end
      StDataLo: state_d = mii_rx_dv_i ? StDataHi : StIdle;
      StDataHi: begin
        if (!mii_rx_dv_i)   state_d = StIdle;
        else if (push_fail) state_d = StDrop;
        else                state_d = StDataLo;
      end
      StDrop: begin
        if (!mii_rx_dv_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM output decode
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    stage_new = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    end_frame = 1'b0;
    end_err   = 1'b0;
    unique case (state_q)
      StPreamble: begin
        cnt_clr = mii_rx_dv_i && (mii_rx_data_i == 4'hd);
      end
      StDataLo: begin
        if (!mii_rx_dv_i) begin
          end_frame = 1'b1;
          end_err   = (cnt_q == 11'd0) || (cnt_q > MaxLen);
          push      = stg_valid_q;
          push_last = 1'b1;
        end
      end
      StDataHi: begin
        push = stg_valid_q;
        if (mii_rx_dv_i) begin
          cnt_inc   = 1'b1;
          stage_new = 1'b1;
        end else begin
          // Trailing odd nibble is discarded and the frame is flagged bad.
          end_frame = 1'b1;
          end_err   = 1'b1;
          push_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath: nibble capture, staging register, byte counter, status flags
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      armed_q     <= 1'b0;
      lo_q        <= 4'h0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= 8'h00;
      cnt_q       <= 11'd0;
      done_q      <= 1'b0;
      len_q       <= 11'd0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (cke_i) begin
      armed_q <= armed_q | ~mii_rx_dv_i;
      if (state_q == StDataLo && mii_rx_dv_i) lo_q <= mii_rx_data_i;

      if (push_fail) begin
        stg_valid_q <= 1'b0;
      end else if (stage_new) begin
        stg_valid_q <= 1'b1;
        stg_data_q  <= {mii_rx_data_i, lo_q};
      end else if (end_frame) begin
        stg_valid_q <= 1'b0;
      end

      if (cnt_clr)                        cnt_q <= 11'd0;
      else if (cnt_inc && cnt_q != CntMax) cnt_q <= cnt_q + 11'd1;

      // A frame that lost a byte to overflow never reports completion.
      done_q <= end_frame && !push_fail;
      if (end_frame && !push_fail) begin
        len_q <= cnt_q;
        err_q <= end_err;
      end

      if (push_fail) ovf_q <= 1'b1;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (cke_i) begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are only observed through the empty-gated outputs
  always_ff @(posedge clk_i) begin
    if (cke_i && push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {push_last, stg_data_q};
  end

  // Output drive
  always_comb begin
    m_valid_o    = !fifo_empty;
    m_data_o     = fifo_empty ? 8'h00 : rd_word[7:0];
    m_last_o     = fifo_empty ? 1'b0 : rd_word[8];
    frame_done_o = done_q;
    frame_len_o  = len_q;
    frame_err_o  = err_q;
    overflow_o   = ovf_q;
  end

endmodule

// File: tb/tb_iob_eth_mii_rx.sv
// Directed bench for iob_eth_mii_rx.
module tb_iob_eth_mii_rx;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        cke_i = 1'b1;
  logic        mii_rx_dv_i = 1'b0;
  logic [3:0]  mii_rx_data_i = 4'h0;
  logic [7:0]  m_data_o;
  logic        m_last_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic        frame_done_o;
  logic [10:0] frame_len_o;
  logic        frame_err_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] rx_q[$];
  int         done_cnt = 0;
  logic [10:0] last_len = '0;
  logic        last_err = 1'b0;

  iob_eth_mii_rx #(.FIFO_AW(2), .MAX_LEN(1518)) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .cke_i         (cke_i),
    .mii_rx_dv_i   (mii_rx_dv_i),
    .mii_rx_data_i (mii_rx_data_i),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .frame_done_o  (frame_done_o),
    .frame_len_o   (frame_len_o),
    .frame_err_o   (frame_err_o),
    .overflow_o    (overflow_o)
  );

  always #20 clk_i = ~clk_i;

  // Record transfers and frame completions mid-cycle, when everything is stable
  always @(negedge clk_i) begin
    if (arstn_i && cke_i) begin
      if (m_valid_o && m_ready_i) rx_q.push_back({m_last_o, m_data_o});
      if (frame_done_o) begin
        done_cnt++;
        last_len = frame_len_o;
        last_err = frame_err_o;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nib(input logic dv, input logic [3:0] n);
    mii_rx_dv_i   = dv;
    mii_rx_data_i = n;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) nib(1'b0, 4'h0);
  endtask

  task automatic send_preamble();
    repeat (15) nib(1'b1, 4'h5);
    nib(1'b1, 4'hd);
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(1'b1, b[3:0]);
    nib(1'b1, b[7:4]);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    done_cnt = 0;
  endtask

  // Long frame of byte values i[7:0]; checks content, last flag and status
  task automatic run_len(input int n, input logic exp_err);
    int bad;
    clear_mon();
    send_preamble();
    for (int i = 0; i < n; i++) send_byte(8'(i));
    idle(6);
    bad = 0;
    if (rx_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        if (rx_q[i] !== {(i == n - 1) ? 1'b1 : 1'b0, 8'(i)}) bad++;
      end
    end
    check_eq($sformatf("len%0d_count", n), rx_q.size(), n);
    check_eq($sformatf("len%0d_bad_bytes", n), bad, 0);
    check_eq($sformatf("len%0d_done", n), done_cnt, 1);
    check_eq($sformatf("len%0d_len", n), last_len, n);
    check_eq($sformatf("len%0d_err", n), last_err, exp_err);
  endtask

  initial begin
    // Reset state
    #5;
    check_eq("rst_valid", m_valid_o, 0);
    check_eq("rst_done", frame_done_o, 0);
    check_eq("rst_len", frame_len_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    idle(3);

    // Clean three-byte frame
    clear_mon();
    send_preamble();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hab);
    idle(5);
    check_eq("clean_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check_eq("clean_b0", rx_q[0], {1'b0, 8'h12});
      check_eq("clean_b1", rx_q[1], {1'b0, 8'h34});
      check_eq("clean_b2", rx_q[2], {1'b1, 8'hab});
    end
    check_eq("clean_done", done_cnt, 1);
    check_eq("clean_len", last_len, 3);
    check_eq("clean_err", last_err, 0);
    check_eq("clean_len_hold", frame_len_o, 3);

    // Odd nibble count
    clear_mon();
    send_preamble();
    nib(1'b1, 4'h1); nib(1'b1, 4'h0); nib(1'b1, 4'h7);
    idle(5);
    check_eq("odd_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check_eq("odd_b0", rx_q[0], {1'b1, 8'h01});
    check_eq("odd_done", done_cnt, 1);
    check_eq("odd_len", last_len, 1);
    check_eq("odd_err", last_err, 1);

    // Zero-byte frame
    clear_mon();
    send_preamble();
    idle(5);
    check_eq("zero_count", rx_q.size(), 0);
    check_eq("zero_done", done_cnt, 1);
    check_eq("zero_len", last_len, 0);
    check_eq("zero_err", last_err, 1);

    // Bad preamble is dropped; status holds the previous frame's values
    clear_mon();
    nib(1'b1, 4'h5); nib(1'b1, 4'h5); nib(1'b1, 4'h3); nib(1'b1, 4'h5); nib(1'b1, 4'hd);
    send_byte(8'h21); send_byte(8'h43);
    idle(5);
    check_eq("badpre_count", rx_q.size(), 0);
    check_eq("badpre_done", done_cnt, 0);
    check_eq("badpre_len_hold", frame_len_o, 0);
    check_eq("badpre_err_hold", frame_err_o, 1);

    // Next valid frame, with a clock-enable stall mid-frame
    send_preamble();
    cke_i = 1'b0;
    idle(3);
    cke_i = 1'b1;
    send_byte(8'h5a);
    idle(5);
    check_eq("after_bad_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check_eq("after_bad_b0", rx_q[0], {1'b1, 8'h5a});
    check_eq("after_bad_done", done_cnt, 1);
    check_eq("after_bad_len", last_len, 1);
    check_eq("after_bad_err", last_err, 0);

    // Backpressure: eight bytes into a four-entry FIFO
    clear_mon();
    m_ready_i = 1'b0;
    send_preamble();
    for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i));
    idle(5);
    check_eq("bp_ovf", overflow_o, 1);
    check_eq("bp_done", done_cnt, 0);
    check_eq("bp_valid", m_valid_o, 1);
    check_eq("bp_stall_data", m_data_o, 8'h80);
    m_ready_i = 1'b1;
    idle(8);
    check_eq("bp_drain_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) check_eq($sformatf("bp_b%0d", i), rx_q[i], {1'b0, 8'h80 + 8'(i)});
    end
    check_eq("bp_ovf_sticky", overflow_o, 1);

    // Reset in the middle of a frame
    clear_mon();
    send_preamble();
    for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i));
    #3;
    arstn_i = 1'b0;
    #1;
    check_eq("mrst_valid", m_valid_o, 0);
    check_eq("mrst_last", m_last_o, 0);
    check_eq("mrst_data", m_data_o, 0);
    check_eq("mrst_done", frame_done_o, 0);
    check_eq("mrst_len", frame_len_o, 0);
    check_eq("mrst_err", frame_err_o, 0);
    check_eq("mrst_ovf", overflow_o, 0);
    @(posedge clk_i); #1;
    nib(1'b1, 4'h5);
    arstn_i = 1'b1;
    clear_mon();
    // Leftover activity after release must not be taken as a frame
    nib(1'b1, 4'h5); nib(1'b1, 4'h5); nib(1'b1, 4'hd); send_byte(8'h77);
    idle(4);
    check_eq("mrst_resync_count", rx_q.size(), 0);
    check_eq("mrst_resync_done", done_cnt, 0);
    send_preamble();
    send_byte(8'hc3); send_byte(8'h3c);
    idle(5);
    check_eq("mrst_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check_eq("mrst_b0", rx_q[0], {1'b0, 8'hc3});
      check_eq("mrst_b1", rx_q[1], {1'b1, 8'h3c});
    end
    check_eq("mrst_done2", done_cnt, 1);
    check_eq("mrst_len2", last_len, 2);
    check_eq("mrst_err2", last_err, 0);

    // Length limit: exactly MAX_LEN is fine, beyond it is flagged but forwarded
    run_len(1518, 1'b0);
    run_len(1520, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
